// File: rtl/ysyx_25030085_alu_issue_if.sv
// Operand/writeback bundle between the ALU issue unit and its environment.
// master = issue unit side, slave = decoder/regfile/ALU/WBU side.
interface ysyx_25030085_alu_issue_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [REG_AW-1:0] in_rs1;
    logic [REG_AW-1:0] in_rs2;
    logic [REG_AW-1:0] in_rd;
    logic              in_rd_wen;
    logic [XLEN-1:0]   in_imm;
    logic [XLEN-1:0]   in_pc;
    logic [3:0]        in_aluop;
    logic              in_alusrc;

    logic [REG_AW-1:0] rf_raddr1;
    logic [REG_AW-1:0] rf_raddr2;
    logic [XLEN-1:0]   rf_rdata1;
    logic [XLEN-1:0]   rf_rdata2;

    logic [XLEN-1:0]   alu_rs1_data;
    logic [XLEN-1:0]   alu_rs2_data;
    logic [XLEN-1:0]   alu_imm;
    logic [XLEN-1:0]   alu_pc;
    logic [3:0]        alu_op;
    logic              alu_src;
    logic [XLEN-1:0]   alu_result;

    logic              wb_valid;
    logic              wb_ready;
    logic [REG_AW-1:0] wb_rd;
    logic [XLEN-1:0]   wb_data;
    logic              wb_wen;

    modport master (
        input  in_valid, in_rs1, in_rs2, in_rd, in_rd_wen, in_imm, in_pc, in_aluop, in_alusrc,
        output in_ready,
        output rf_raddr1, rf_raddr2,
        input  rf_rdata1, rf_rdata2,
        output alu_rs1_data, alu_rs2_data, alu_imm, alu_pc, alu_op, alu_src,
        input  alu_result,
        output wb_valid, wb_rd, wb_data, wb_wen,
        input  wb_ready
    );

    modport slave (
        output in_valid, in_rs1, in_rs2, in_rd, in_rd_wen, in_imm, in_pc, in_aluop, in_alusrc,
        input  in_ready,
        input  rf_raddr1, rf_raddr2,
        output rf_rdata1, rf_rdata2,
        input  alu_rs1_data, alu_rs2_data, alu_imm, alu_pc, alu_op, alu_src,
        output alu_result,
        input  wb_valid, wb_rd, wb_data, wb_wen,
        output wb_ready
    );
endinterface

// File: rtl/ysyx_25030085_alu_issue.sv
// ALU issue unit: IDLE -> READ -> EXEC -> WB, one instruction in flight.
// Optional macro ISSUE_OVERLAP_EN lets a new instruction be accepted on the writeback edge.
module ysyx_25030085_alu_issue #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    ysyx_25030085_alu_issue_if.master     bus,
    output logic [1:0]                    dbg_state
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_t;

    state_t            state;
    logic              ready_q;
    logic [REG_AW-1:0] rs1_q;
    logic [REG_AW-1:0] rs2_q;
    logic [REG_AW-1:0] rd_q;
    logic              rd_wen_q;
    logic [XLEN-1:0]   imm_q;
    logic [XLEN-1:0]   pc_q;
    logic [3:0]        aluop_q;
    logic              alusrc_q;
    logic              accept;

    // Both handshakes: a transfer happens on a rising edge where valid and ready
    // are both high; valid and payload stay stable until that edge.
`ifdef ISSUE_OVERLAP_EN
    assign bus.in_ready = ready_q | ((state == WB) & bus.wb_ready);
`else
    assign bus.in_ready = ready_q;
`endif

    assign accept        = bus.in_valid & bus.in_ready;
    assign bus.rf_raddr1 = rs1_q;
    assign bus.rf_raddr2 = rs2_q;
    assign dbg_state     = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            ready_q          <= 1'b1;
            rs1_q            <= '0;
            rs2_q            <= '0;
            rd_q             <= '0;
            rd_wen_q         <= 1'b0;
            imm_q            <= '0;
            pc_q             <= '0;
            aluop_q          <= '0;
            alusrc_q         <= 1'b0;
            bus.alu_rs1_data <= '0;
            bus.alu_rs2_data <= '0;
            bus.alu_imm      <= '0;
            bus.alu_pc       <= '0;
            bus.alu_op       <= '0;
            bus.alu_src      <= 1'b0;
            bus.wb_valid     <= 1'b0;
            bus.wb_rd        <= '0;
            bus.wb_data      <= '0;
            bus.wb_wen       <= 1'b0;
        end else begin
            // in_ready is only high in IDLE, or in WB with the overlap path enabled.
            if (accept) begin
                rs1_q    <= bus.in_rs1;
                rs2_q    <= bus.in_rs2;
                rd_q     <= bus.in_rd;
                rd_wen_q <= bus.in_rd_wen;
                imm_q    <= bus.in_imm;
                pc_q     <= bus.in_pc;
                aluop_q  <= bus.in_aluop;
                alusrc_q <= bus.in_alusrc;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        ready_q <= 1'b0;
                        state   <= READ;
                    end
                end
                READ: begin
                    // x0 is hardwired zero whatever the regfile returns.
                    bus.alu_rs1_data <= (rs1_q == '0) ? '0 : bus.rf_rdata1;
                    bus.alu_rs2_data <= (rs2_q == '0) ? '0 : bus.rf_rdata2;
                    bus.alu_imm      <= imm_q;
                    bus.alu_pc       <= pc_q;
                    bus.alu_op       <= aluop_q;
                    bus.alu_src      <= alusrc_q;
                    state            <= EXEC;
                end
                EXEC: begin
                    bus.wb_data  <= bus.alu_result;
                    bus.wb_rd    <= rd_q;
                    bus.wb_wen   <= rd_wen_q & (rd_q != '0);
                    bus.wb_valid <= 1'b1;
                    state        <= WB;
                end
                WB: begin
                    if (bus.wb_ready) begin
                        bus.wb_valid <= 1'b0;
                        bus.wb_wen   <= 1'b0;
                        if (accept) begin
                            state <= READ;
                        end else begin
                            ready_q <= 1'b1;
                            state   <= IDLE;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_25030085_alu_issue.sv
// Directed bench for the ALU issue unit: scoreboard of expected writebacks and EXEC operands.
module tb_ysyx_25030085_alu_issue;
  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ysyx_25030085_alu_issue_if #(.XLEN(XLEN), .REG_AW(REG_AW)) bus ();
  logic [1:0] dbg_state;

  ysyx_25030085_alu_issue #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // environment: regfile (x0 reads garbage to prove forcing) and an add-only ALU
  logic [XLEN-1:0] rf [32];
  assign bus.rf_rdata1  = (bus.rf_raddr1 == '0) ? 32'hDEAD_BEEF : rf[bus.rf_raddr1];
  assign bus.rf_rdata2  = (bus.rf_raddr2 == '0) ? 32'hDEAD_BEEF : rf[bus.rf_raddr2];
  assign bus.alu_result = bus.alu_rs1_data + (bus.alu_src ? bus.alu_imm : bus.alu_rs2_data);

  int  n_cmp    = 0;
  int  n_err    = 0;
  int  wr_count = 0;
  int  hs_count = 0;
  time last_hs  = 0;
  time prev_hs  = 0;
  time t_acc    = 0;

  logic [REG_AW+XLEN:0] exp_q[$];
  logic [2*XLEN-1:0]    exe_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (!rst && bus.wb_valid && bus.wb_ready && bus.wb_wen && bus.wb_rd != '0) begin
      rf[bus.wb_rd] = bus.wb_data;
      wr_count = wr_count + 1;
    end
  end

  // monitor
  always @(negedge clk) begin : monitor
    logic [2*XLEN-1:0]    ee;
    logic [REG_AW+XLEN:0] ew;
    if (!rst) begin
      if (dbg_state == 2'd2) begin
        if (exe_q.size() == 0) check("exec_unexpected", 1, 0);
        else begin
          ee = exe_q.pop_front();
          check("alu_rs1_data", bus.alu_rs1_data, ee[2*XLEN-1:XLEN]);
          check("alu_rs2_data", bus.alu_rs2_data, ee[XLEN-1:0]);
        end
      end
      if (bus.wb_valid && bus.wb_ready) begin
        if (exp_q.size() == 0) check("wb_unexpected", 1, 0);
        else begin
          ew = exp_q.pop_front();
          check("wb_rd",   bus.wb_rd,   ew[REG_AW+XLEN:XLEN+1]);
          check("wb_wen",  bus.wb_wen,  ew[XLEN]);
          check("wb_data", bus.wb_data, ew[XLEN-1:0]);
        end
        prev_hs  = last_hs;
        last_hs  = $time + 5;
        hs_count = hs_count + 1;
      end
    end
  end

  // driver tasks
  task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic wen, input logic [31:0] imm, input logic src,
                       input logic [31:0] e1, input logic [31:0] e2,
                       input logic ewen, input logic [31:0] edata);
    int guard;
    @(posedge clk); #1;
    bus.in_rs1 = rs1; bus.in_rs2 = rs2; bus.in_rd = rd; bus.in_rd_wen = wen;
    bus.in_imm = imm; bus.in_pc = 32'h8000_0000 + {27'd0, rd}; bus.in_aluop = 4'b0000;
    bus.in_alusrc = src; bus.in_valid = 1'b1;
    exe_q.push_back({e1, e2});
    exp_q.push_back({rd, ewen, edata});
    #1;
    guard = 0;
    while (!bus.in_ready) begin
      @(posedge clk); #2;
      guard++;
      if (guard > 50) begin
        check("accept_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    t_acc = $time;
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic wait_wb_valid();
    int guard;
    guard = 0;
    @(negedge clk);
    while (!bus.wb_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.wb_valid) check("wb_valid_timeout", 0, 1);
  endtask

  task automatic wait_hs(input int target);
    int guard;
    guard = 0;
    while (hs_count < target && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    if (hs_count < target) check("handshake_timeout", hs_count, target);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int wr_before;
    for (int i = 0; i < 32; i++) rf[i] = '0;
    rf[1] = 32'd5;
    rf[2] = 32'd7;
    rf[4] = 32'h55;
    rf[7] = 32'h77;
    bus.in_valid = 1'b0; bus.in_rs1 = '0; bus.in_rs2 = '0; bus.in_rd = '0;
    bus.in_rd_wen = 1'b0; bus.in_imm = '0; bus.in_pc = '0; bus.in_aluop = '0;
    bus.in_alusrc = 1'b0; bus.wb_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready",  bus.in_ready, 1);
    check("rst_wb_valid",  bus.wb_valid, 0);
    check("rst_wb_wen",    bus.wb_wen, 0);
    check("rst_wb_data",   bus.wb_data, 0);
    check("rst_raddr1",    bus.rf_raddr1, 0);
    check("rst_alu_rs1",   bus.alu_rs1_data, 0);
    check("rst_alu_imm",   bus.alu_imm, 0);
    check("rst_state",     dbg_state, 0);

    // register operands: 5 + 7, latency accept -> handshake = 3 cycles
    issue(5'd1, 5'd2, 5'd3, 1'b1, 32'd0, 1'b0, 32'd5, 32'd7, 1'b1, 32'd12);
    wait_hs(1);
    check("latency", last_hs - t_acc, 30);
    check("rf_x3", rf[3], 32'd12);

    // immediate wrap-around
    rf[1] = 32'hFFFF_FFFF;
    issue(5'd1, 5'd0, 5'd4, 1'b1, 32'd1, 1'b1, 32'hFFFF_FFFF, 32'd0, 1'b1, 32'd0);
    wait_hs(2);
    check("rf_x4", rf[4], 32'd0);

    // rs1 = x0 reads zero, rd = x0 suppresses wen
    issue(5'd0, 5'd0, 5'd0, 1'b1, 32'd9, 1'b1, 32'd0, 32'd0, 1'b0, 32'd9);
    wait_hs(3);

    // in_rd_wen = 0: no regfile write
    issue(5'd2, 5'd0, 5'd7, 1'b0, 32'd1, 1'b1, 32'd7, 32'd0, 1'b0, 32'd8);
    wait_hs(4);
    check("rf_x7_kept", rf[7], 32'h77);

    // backpressure: wb_ready low, outputs frozen
    bus.wb_ready = 1'b0;
    issue(5'd1, 5'd2, 5'd8, 1'b1, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd7, 1'b1, 32'd6);
    wait_wb_valid();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_wb_valid", bus.wb_valid, 1);
      check("bp_wb_data",  bus.wb_data, 32'd6);
      check("bp_in_ready", bus.in_ready, 0);
    end
    @(posedge clk); #1 bus.wb_ready = 1'b1;
    wait_hs(5);
    check("bp_idle_ready", bus.in_ready, 1);
    check("bp_idle_valid", bus.wb_valid, 0);
    check("rf_x8", rf[8], 32'd6);

    // back-to-back: A writes x5 = 3, B reads x5 and adds 1
    issue(5'd0, 5'd0, 5'd5, 1'b1, 32'd3, 1'b1, 32'd0, 32'd0, 1'b1, 32'd3);
    issue(5'd5, 5'd0, 5'd6, 1'b1, 32'd1, 1'b1, 32'd3, 32'd0, 1'b1, 32'd4);
    wait_hs(7);
`ifdef ISSUE_OVERLAP_EN
    check("wb_spacing", last_hs - prev_hs, 30);
`else
    check("wb_spacing", last_hs - prev_hs, 40);
`endif
    check("rf_x6", rf[6], 32'd4);

    // reset while holding in WB
    bus.wb_ready = 1'b0;
    issue(5'd2, 5'd2, 5'd9, 1'b1, 32'd0, 1'b0, 32'd7, 32'd7, 1'b1, 32'd14);
    wait_wb_valid();
    wr_before = wr_count;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(posedge clk); #1 rst = 1'b0;
    exp_q.delete();
    exe_q.delete();
    @(negedge clk);
    check("rst2_in_ready", bus.in_ready, 1);
    check("rst2_wb_valid", bus.wb_valid, 0);
    check("rst2_wb_wen",   bus.wb_wen, 0);
    check("rst2_wb_data",  bus.wb_data, 0);
    check("rst2_alu_rs1",  bus.alu_rs1_data, 0);
    check("rst2_raddr1",   bus.rf_raddr1, 0);
    check("rst2_no_write", wr_count, wr_before);
    check("rf_x9", rf[9], 32'd0);

    // normal operation after reset
    bus.wb_ready = 1'b1;
    issue(5'd1, 5'd2, 5'd10, 1'b1, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd7, 1'b1, 32'd6);
    wait_hs(8);
    check("rf_x10", rf[10], 32'd6);
    check("exp_q_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
